// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: icache read port, redirect input and decode-side fetch buffer head.
interface instr_fetch_unit_if;
  logic        icache_read;
  logic [31:0] icache_rdaddr;
  logic [31:0] icache_rddata;
  logic        icache_rdstall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_adel;
  modport master (
    output icache_read, icache_rdaddr, if_valid, if_pc, if_instr, if_adel,
    input  icache_rddata, icache_rdstall, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  icache_read, icache_rdaddr, if_valid, if_pc, if_instr, if_adel,
    output icache_rddata, icache_rdstall, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential PC fetch into the icache with a {pc, instr} buffer toward decode.
// Optional IFU_ALIGN_CHECK_EN reports misaligned redirect targets as address-error entries.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
  state_t r_state, w_next;
  logic [31:0] r_pc, r_target, r_resp_pc, w_rpc, w_tgt;
  logic r_resp_pending, r_resp_adel, r_idle;
  logic [AW:0] r_count;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW+1:0] w_occ;
  logic [31:0] r_mem_pc [FIFO_DEPTH];
  logic [31:0] r_mem_instr [FIFO_DEPTH];
  logic w_deq, w_enq, w_read, w_accept, w_hold_now, w_load, w_tmis;

`ifdef IFU_ALIGN_CHECK_EN
  logic r_mem_adel [FIFO_DEPTH];
  assign w_rpc = bus.redirect_pc;
  assign w_tmis = |w_tgt[1:0];
  assign bus.if_adel = bus.if_valid && r_mem_adel[r_rp];
  always_ff @(posedge clk)
    if (w_enq) r_mem_adel[r_wp] <= r_resp_adel;
`else
  assign w_rpc = {bus.redirect_pc[31:2], 2'b00};
  assign w_tmis = 1'b0;
  assign bus.if_adel = 1'b0;
`endif

  // A stalled request must stay presented: the cache uses the live address during refill
  always_comb begin
    w_deq = (r_count != '0) && bus.id_ready;
    w_enq = r_resp_pending && !bus.redirect_valid;
    w_occ = (AW+2)'(r_count) + (AW+2)'(r_resp_pending) - (AW+2)'(w_deq);
    w_read = (r_state == FETCH) ? (!r_idle && w_occ < (AW+2)'(FIFO_DEPTH)) : (r_state == HOLD);
    w_accept = w_read && !bus.icache_rdstall;
    w_hold_now = bus.redirect_valid && w_read && bus.icache_rdstall;
    w_load = (r_state == HOLD) ? w_accept : (bus.redirect_valid && !w_hold_now);
    w_tgt = bus.redirect_valid ? w_rpc : r_target;
    w_next = (r_state == HOLD) ? (w_accept ? FETCH : HOLD) : (w_hold_now ? HOLD : FETCH);
  end

  assign bus.icache_read   = w_read;
  assign bus.icache_rdaddr = r_pc;
  assign bus.if_valid      = r_count != '0;
  assign bus.if_pc         = bus.if_valid ? r_mem_pc[r_rp] : '0;
  assign bus.if_instr      = bus.if_valid ? r_mem_instr[r_rp] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= BOOT;
      r_pc           <= RESET_PC;
      r_target       <= RESET_PC;
      r_resp_pc      <= '0;
      r_resp_pending <= 1'b0;
      r_resp_adel    <= 1'b0;
      r_idle         <= 1'b0;
      r_count        <= '0;
      r_wp           <= '0;
      r_rp           <= '0;
    end else begin
      r_state <= w_next;
      if (bus.redirect_valid) r_target <= w_rpc;
      r_pc           <= w_load ? w_tgt : w_accept ? r_pc + 32'd4 : r_pc;
      r_idle         <= w_load ? w_tmis : r_idle;
      r_resp_pending <= w_load ? w_tmis : (w_accept && r_state == FETCH);
      r_resp_pc      <= w_load ? w_tgt : r_pc;
      r_resp_adel    <= w_load && w_tmis;
      r_count        <= bus.redirect_valid ? '0 : r_count + (AW+1)'(w_enq) - (AW+1)'(w_deq);
      r_wp           <= bus.redirect_valid ? '0 : r_wp + AW'(w_enq);
      r_rp           <= bus.redirect_valid ? '0 : r_rp + AW'(w_deq);
    end
  end

  always_ff @(posedge clk)
    if (w_enq) begin
      r_mem_pc[r_wp]    <= r_resp_pc;
      r_mem_instr[r_wp] <= r_resp_adel ? '0 : bus.icache_rddata;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random checks of the fetch unit against a decode-stream model.
module tb_instr_fetch_unit;
  localparam logic [31:0] RPC = 32'hBFC00000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  instr_fetch_unit_if bus();
  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ndeq = 0;
  logic [31:0] exp_pc, held_addr, last_addr;
  logic exp_adel, dead, held, last_acc;
  logic o_read, o_valid, o_adel;
  logic [31:0] o_addr, o_pc, o_instr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E3779B1 ^ 32'h13579BDF;
  endfunction

  function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef IFU_ALIGN_CHECK_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic sample();
    o_read  = bus.icache_read;
    o_addr  = bus.icache_rdaddr;
    o_valid = bus.if_valid;
    o_pc    = bus.if_pc;
    o_instr = bus.if_instr;
    o_adel  = bus.if_adel;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.icache_rdstall = 1'($urandom);
    bus.id_ready = 1'($urandom);
    @(posedge clk); #1;
    #1 sample();
    chk("rst_read", 32'(o_read), 32'd0);
    chk("rst_addr", o_addr, RPC);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_adel", 32'(o_adel), 32'd0);
    rst = 1'b0;
    exp_pc = RPC;
    exp_adel = 1'b0;
    dead = 1'b0;
    held = 1'b0;
    last_acc = 1'b0;
  endtask

  // One clock: cache answers the address it accepted last cycle; decode stream must run
  // sequentially from the last redirect target (or reset PC).
  task automatic cyc(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk); #1;
    bus.icache_rddata = last_acc ? mem(last_addr) : $urandom;
    bus.icache_rdstall = st;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.id_ready = rdy;
    #1 sample();
    if (held) begin
      chk("hold_read", 32'(o_read), 32'd1);
      chk("hold_addr", o_addr, held_addr);
    end
    if (dead) begin
      chk("idle_valid", 32'(o_valid), 32'd0);
      chk("idle_read", 32'(o_read), 32'd0);
    end else if (o_valid && rdy) begin
      chk("pc", o_pc, exp_pc);
      chk("instr", o_instr, exp_adel ? 32'd0 : mem(exp_pc));
      chk("adel", 32'(o_adel), 32'(exp_adel));
      ndeq++;
      if (exp_adel) dead = 1'b1;
      else exp_pc += 32'd4;
    end
    if (rv) begin
      exp_pc = tgt(rpc);
`ifdef IFU_ALIGN_CHECK_EN
      exp_adel = |rpc[1:0];
`else
      exp_adel = 1'b0;
`endif
      dead = 1'b0;
    end
    held = o_read && st;
    held_addr = o_addr;
    last_acc = o_read && !st;
    last_addr = o_addr;
  endtask

  initial begin
    bus.icache_rddata = '0;
    bus.icache_rdstall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b1;
    do_reset();
    cyc(0, 0, 0, 1);
    chk("a1_read", 32'(o_read), 32'd1);
    chk("a1_addr", o_addr, RPC);
    chk("a1_valid", 32'(o_valid), 32'd0);
    cyc(0, 0, 0, 1);
    chk("a2_addr", o_addr, RPC + 32'd4);
    chk("a2_valid", 32'(o_valid), 32'd0);
    cyc(1, 0, 0, 1);
    chk("a3_valid", 32'(o_valid), 32'd1);
    chk("a3_pc", o_pc, RPC);
    chk("a3_addr", o_addr, RPC + 32'd8);
    for (int i = 0; i < 19; i++) begin
      cyc(1, 0, 0, 1);
      chk("b_read", 32'(o_read), 32'd1);
      chk("b_addr", o_addr, RPC + 32'd8);
    end
    cyc(0, 0, 0, 1);
    chk("b_acc_addr", o_addr, RPC + 32'd8);
    cyc(0, 0, 0, 1);
    chk("b_next_addr", o_addr, RPC + 32'd12);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    chk("c_read", 32'(o_read), 32'd0);
    chk("c_valid", 32'(o_valid), 32'd1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    chk("d_addr", o_addr, RPC + 32'h10);
    cyc(0, 1, 32'h80000180, 1);
    cyc(0, 0, 0, 1);
    chk("d_valid", 32'(o_valid), 32'd0);
    chk("d_read", 32'(o_read), 32'd1);
    chk("d_addr2", o_addr, 32'h80000180);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1, i == 3, 32'h80000200, 1);
      chk("e_read", 32'(o_read), 32'd1);
      chk("e_addr", o_addr, RPC + 32'h20);
    end
    cyc(0, 0, 0, 1);
    chk("e_acc_addr", o_addr, RPC + 32'h20);
    cyc(0, 0, 0, 1);
    chk("e_tgt_addr", o_addr, 32'h80000200);
    chk("e_valid", 32'(o_valid), 32'd0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("e_first_valid", 32'(o_valid), 32'd1);
    chk("e_first_pc", o_pc, 32'h80000200);

`ifdef IFU_ALIGN_CHECK_EN
    cyc(0, 1, 32'h80000002, 1);
    cyc(0, 0, 0, 1);
    chk("f_read", 32'(o_read), 32'd0);
    cyc(0, 0, 0, 1);
    chk("f_valid", 32'(o_valid), 32'd1);
    chk("f_pc", o_pc, 32'h80000002);
    chk("f_instr", o_instr, 32'd0);
    chk("f_adel", 32'(o_adel), 32'd1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, RPC + 32'h100, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(7) != 0) r[1:0] = 2'b00;
      if (i == 1500) do_reset();
      cyc($urandom_range(3) == 0, $urandom_range(24) == 0, r, $urandom_range(3) != 0);
    end
    chk("progress", 32'(ndeq > 500), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction cache.
- Generates the sequential PC and drives the cache read port (read / rdaddr in; rddata / rdstall out).
- Honours the cache's contract: address held during stall, data returned one cycle after acceptance.
- Buffers fetched {pc, instr} pairs in a small FIFO toward decode and handles branch/exception redirects without corrupting an in-progress cache refill.

Parameters:
RESET_PC, 32'hBFC00000, first fetch address after reset
FIFO_DEPTH, 2, fetch buffer entries; power of 2, range 2..8

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
icache_read  output  1  read request to instruction cache
icache_rdaddr  output  32  fetch address to cache
icache_rddata  input  32  instruction for the address accepted in the previous cycle
icache_rdstall  input  1  cache busy; the current request is not accepted
redirect_valid  input  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  input  32  redirect target
id_ready  input  1  decode consumes head entry this cycle
if_valid  output  1  head entry valid
if_pc  output  32  PC of head entry
if_instr  output  32  instruction of head entry
if_adel  output  1  head entry carries an address-error (misaligned fetch) flag

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: icache_read=0, icache_rdaddr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, if_adel=0; FIFO empty; resp_pending=0; state=BOOT.
- States:
  - BOOT: one cycle after rst deasserts, then -> FETCH.
  - FETCH: normal issue.
  - HOLD: a redirect arrived while a stalled request was outstanding.
- Acceptance: a request is accepted in cycle t iff icache_read=1 and icache_rdstall=0. pc <= pc+4 (32-bit wrap). resp_pending <= 1 unless squashed.
- Stall hold: while icache_read=1 and icache_rdstall=1, icache_rdaddr and icache_read are held unchanged. This is mandatory because the cache uses the live address during refill.
- Response: when resp_pending=1 at t+1, {rdaddr_of_t, icache_rddata} is written to the FIFO tail. The entry is visible at decode at t+2. Hit latency address->if_valid = 2 cycles.
- Issue condition in FETCH: icache_read = (count + resp_pending - deq) < FIFO_DEPTH, where deq = if_valid & id_ready. This gives full throughput of 1 instr/cycle on hits with FIFO_DEPTH=2.
- FIFO:
  - if_valid = (count != 0); if_pc / if_instr / if_adel come from the head.
  - Simultaneous enqueue and dequeue keeps count.
  - Full FIFO never overflows, guaranteed by the issue condition.
- Redirect, no stalled request outstanding:
  - FIFO cleared; resp_pending forced to 0 (a response arriving this cycle is discarded).
  - pc <= redirect_pc; next cycle issues redirect_pc.
  - A dequeue in the redirect cycle is harmless.
- Redirect while icache_read=1 and icache_rdstall=1:
  - FIFO cleared; target latched; state -> HOLD.
  - Address stays held until the stall drops. The access completes, and its response is squashed.
  - Then pc <= latched target; state -> FETCH.
- Second redirect in HOLD overwrites the latched target (last wins).
- BOOT, HOLD: no new fetch addresses are issued (HOLD only keeps the stalled request presented).
- rst mid-operation returns everything to reset values regardless of cache state.

Optional Feature:
IFU_ALIGN_CHECK_EN
- Defined: a redirect_pc with [1:0] != 0 issues no cache read. Instead one FIFO entry {pc=redirect_pc, instr=0, adel=1} is enqueued. Fetch then idles until the next redirect.
- Undefined: redirect_pc[1:0] is forced to 2'b00, and if_adel is tied 0.

Test Plan:
- Reset release, cache always hits, id_ready=1 -> icache_rdaddr BFC00000, BFC00004, ... one per cycle; first if_valid 3 cycles after rst low, if_pc=BFC00000, then one new if_pc per cycle.
- icache_rdstall=1 for 20 cycles on address BFC00008 -> rdaddr stays BFC00008 and icache_read stays 1 throughout; no FIFO write; resumes at BFC0000C after the stall.
- id_ready=0 with FIFO_DEPTH=2 -> exactly 2 entries buffered, icache_read=0, no lost or duplicated PC when id_ready returns to 1.
- redirect_valid with redirect_pc=80000180 in the cycle a response for BFC00010 is pending -> FIFO empty next cycle, BFC00010 never appears on if_pc, next accepted address 80000180.
- Redirect to 80000200 during a 16-cycle miss stall on BFC00020 -> rdaddr held at BFC00020 until the stall drops, its data discarded, then 80000200 issued; first if_pc=80000200.
- With IFU_ALIGN_CHECK_EN, redirect_pc=80000002 -> single entry if_adel=1, if_pc=80000002, if_instr=0; no icache_read until the next redirect.
